// File: rtl/mod_accum_bank.sv
// rtl/mod_accum_bank.sv - bank of modular add/subtract/load accumulators
// Two register stages: S1 captures the request, S2 reads the bank, computes and writes back.
module mod_accum_bank #(
  parameter int BITWIDTH = 16,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  input  logic [CH_W-1:0]     iCh,
  input  logic                iSub,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iQ,
  input  logic [CH_W-1:0]     iRdCh,
  output logic                oValid,
  output logic [CH_W-1:0]     oCh,
  output logic [BITWIDTH-1:0] oData,
  output logic [BITWIDTH-1:0] oRdData
);

  logic                s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]     s1_ch_q, s1_ch_d;
  logic                s1_sub_q, s1_sub_d;
  logic                s1_clr_q, s1_clr_d;
  logic [BITWIDTH-1:0] s1_data_q, s1_data_d;
  logic [BITWIDTH-1:0] s1_mod_q, s1_mod_d;

  logic                s2_valid_q, s2_valid_d;
  logic [CH_W-1:0]     s2_ch_q, s2_ch_d;
  logic                s2_sub_q, s2_sub_d;
  logic                s2_clr_q, s2_clr_d;
  logic [BITWIDTH-1:0] s2_data_q, s2_data_d;
  logic [BITWIDTH-1:0] s2_mod_q, s2_mod_d;
  logic [BITWIDTH-1:0] s2_acc_q, s2_acc_d;

  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [BITWIDTH-1:0] out_data_q, out_data_d;

  logic [BITWIDTH-1:0] acc_q [NUM_CH];
  logic [BITWIDTH-1:0] acc_d [NUM_CH];

  logic [BITWIDTH-1:0] acc_op;
  logic [BITWIDTH:0]   sum_ext;
  logic [BITWIDTH:0]   sum_red;
  logic [BITWIDTH-1:0] add_res;
  logic [BITWIDTH-1:0] sub_res;
  logic [BITWIDTH-1:0] result;

  always_comb begin
    s1_valid_d = iValid;
    s1_ch_d    = iCh;
    s1_sub_d   = iSub;
    s1_clr_d   = iClr;
    s1_data_d  = iData;
    s1_mod_d   = iQ;
  end

  // The bank is sampled one cycle before compute; the forwarding mux below covers that gap.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_ch_d    = s1_ch_q;
    s2_sub_d   = s1_sub_q;
    s2_clr_d   = s1_clr_q;
    s2_data_d  = s1_data_q;
    s2_mod_d   = s1_mod_q;
    s2_acc_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == s1_ch_q) s2_acc_d = acc_q[i];
    end
  end

  always_comb begin
    oRdData = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == iRdCh) oRdData = acc_q[i];
    end
  end

  always_comb begin
    acc_op = s2_acc_q;
    if (out_valid_q && (out_ch_q == s2_ch_q)) acc_op = out_data_q;

    sum_ext = {1'b0, acc_op} + {1'b0, s2_data_q};
    sum_red = sum_ext - {1'b0, s2_mod_q};
    add_res = (sum_ext >= {1'b0, s2_mod_q}) ? sum_red[BITWIDTH-1:0] : sum_ext[BITWIDTH-1:0];

    // Wraps modulo 2^BITWIDTH, so adding the modulus back lands in range.
    sub_res = acc_op - s2_data_q;
    if (acc_op < s2_data_q) sub_res = acc_op - s2_data_q + s2_mod_q;

    if (s2_clr_q)      result = s2_data_q;
    else if (s2_sub_q) result = sub_res;
    else               result = add_res;
  end

  always_comb begin
    out_valid_d = s2_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    for (int i = 0; i < NUM_CH; i++) acc_d[i] = acc_q[i];
    if (s2_valid_q) begin
      out_ch_d   = s2_ch_q;
      out_data_d = result;
      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_W'(i) == s2_ch_q) acc_d[i] = result;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_sub_q    <= 1'b0;
      s1_clr_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_mod_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_sub_q    <= 1'b0;
      s2_clr_q    <= 1'b0;
      s2_data_q   <= '0;
      s2_mod_q    <= '0;
      s2_acc_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_sub_q    <= s1_sub_d;
      s1_clr_q    <= s1_clr_d;
      s1_data_q   <= s1_data_d;
      s1_mod_q    <= s1_mod_d;
      s2_valid_q  <= s2_valid_d;
      s2_ch_q     <= s2_ch_d;
      s2_sub_q    <= s2_sub_d;
      s2_clr_q    <= s2_clr_d;
      s2_data_q   <= s2_data_d;
      s2_mod_q    <= s2_mod_d;
      s2_acc_q    <= s2_acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign oValid = out_valid_q;
  assign oCh    = out_ch_q;
  assign oData  = out_data_q;

endmodule

// File: tb/tb_mod_accum_bank.sv
// tb/tb_mod_accum_bank.sv - self-checking bench for mod_accum_bank
// Reference keeps channel values as plain integers reduced with the % operator.
module tb_mod_accum_bank;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          iValid = 1'b0;
  logic [CW-1:0] iCh = '0;
  logic          iSub = 1'b0;
  logic          iClr = 1'b0;
  logic [W-1:0]  iData = '0;
  logic [W-1:0]  iQ = 16'd13;
  logic [CW-1:0] iRdCh = '0;
  logic          oValid;
  logic [CW-1:0] oCh;
  logic [W-1:0]  oData;
  logic [W-1:0]  oRdData;

  mod_accum_bank #(.BITWIDTH(W), .NUM_CH(N), .CH_W(CW)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iCh(iCh), .iSub(iSub), .iClr(iClr),
    .iData(iData), .iQ(iQ), .iRdCh(iRdCh), .oValid(oValid), .oCh(oCh), .oData(oData),
    .oRdData(oRdData)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int     due;
    int     ch;
    longint data;
  } exp_t;

  int     cyc = 0;
  exp_t   exp_q[$];
  longint m_acc[N];
  longint c_acc[N];
  int     last_ch = 0;
  longint last_data = 0;
  longint obs[$];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     chk_en = 1'b0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Every cycle: either the due result appears, or oValid is low and oCh/oData hold.
  always @(negedge iClk) begin
    if (chk_en && !iRst) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ovalid_pulse", oValid, 1);
        check("och", oCh, e.ch);
        check("odata", oData, e.data);
        c_acc[e.ch] = e.data;
        last_ch = e.ch;
        last_data = e.data;
        obs.push_back(oData);
      end else begin
        check("ovalid_idle", oValid, 0);
        check("och_hold", oCh, last_ch);
        check("odata_hold", oData, last_data);
      end
      check("ordata", oRdData, c_acc[iRdCh]);
    end
  end

  task automatic op(bit v, int ch, bit sub, bit clr, longint d, longint q);
    longint r;
    @(negedge iClk);
    #1;
    iRst = 1'b0;
    iValid = v;
    iCh = CW'(ch);
    iSub = sub;
    iClr = clr;
    iData = W'(d);
    iQ = W'(q);
    iRdCh = CW'($urandom_range(0, N - 1));
    if (v) begin
      if (clr)      r = d;
      else if (sub) r = (m_acc[ch] - d + q) % q;
      else          r = (m_acc[ch] + d) % q;
      m_acc[ch] = r;
      exp_q.push_back('{cyc + 3, ch, r});
    end
  endtask

  task automatic drain(int n);
    repeat (n) op(1'b0, 0, 1'b0, 1'b0, longint'($urandom_range(0, 12)), 13);
  endtask

  task automatic do_reset();
    @(negedge iClk);
    #1;
    iRst = 1'b1;
    iValid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      c_acc[i] = 0;
    end
    last_ch = 0;
    last_data = 0;
    #1;
    check("rst_ovalid", oValid, 0);
    check("rst_och", oCh, 0);
    check("rst_odata", oData, 0);
    for (int i = 0; i < N; i++) begin
      iRdCh = CW'(i);
      #1;
      check("rst_ordata", oRdData, 0);
    end
  endtask

  task automatic check_obs(string name, longint e0, longint e1, longint e2, longint e3, longint e4, int n);
    longint ev[5];
    ev = '{e0, e1, e2, e3, e4};
    check({name, "_count"}, obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) check(name, obs[i], ev[i]);
  endtask

  task automatic read_chk(string name, int ch, longint expv);
    @(negedge iClk);
    #1;
    iRdCh = CW'(ch);
    #1;
    check(name, oRdData, expv);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint q;
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      c_acc[i] = 0;
    end
    #1 iRst = 1'b1;
    #1;
    check("init_ovalid", oValid, 0);
    check("init_och", oCh, 0);
    check("init_odata", oData, 0);
    chk_en = 1'b1;

    obs.delete();
    repeat (5) op(1'b1, 0, 1'b0, 1'b0, 10, 13);
    drain(4);
    check_obs("add_chain", 10, 7, 4, 1, 11, 5);

    obs.delete();
    op(1'b1, 1, 1'b0, 1'b1, 4, 13);
    op(1'b1, 1, 1'b1, 1'b0, 10, 13);
    op(1'b1, 1, 1'b1, 1'b0, 7, 13);
    drain(4);
    check_obs("load_sub", 4, 7, 0, 0, 0, 3);

    do_reset();
    obs.delete();
    for (int i = 0; i < 2; i++) begin
      op(1'b1, 0, 1'b0, 1'b0, 5, 13);
      op(1'b1, 2, 1'b0, 1'b0, 9, 13);
    end
    drain(4);
    check_obs("interleave", 5, 9, 10, 5, 0, 4);
    read_chk("rd_ch0", 0, 10);
    read_chk("rd_ch1", 1, 0);
    read_chk("rd_ch2", 2, 5);
    read_chk("rd_ch3", 3, 0);

    do_reset();
    obs.delete();
    op(1'b1, 0, 1'b0, 1'b0, 3, 13);
    drain(2);
    op(1'b1, 0, 1'b0, 1'b0, 3, 13);
    drain(4);
    check_obs("bubbles", 3, 6, 0, 0, 0, 2);

    op(1'b1, 0, 1'b0, 1'b0, 2, 13);
    op(1'b1, 1, 1'b0, 1'b0, 3, 13);
    do_reset();
    obs.delete();
    op(1'b1, 0, 1'b0, 1'b0, 1, 13);
    drain(4);
    check_obs("post_reset", 1, 0, 0, 0, 0, 1);

    do_reset();
    obs.delete();
    op(1'b1, 0, 1'b0, 1'b1, 65534, 65535);
    op(1'b1, 0, 1'b0, 1'b0, 65534, 65535);
    op(1'b1, 1, 1'b1, 1'b0, 65534, 65535);
    drain(4);
    check_obs("boundary", 65534, 65533, 1, 0, 0, 3);

    for (int p = 0; p < 6; p++) begin
      case (p)
        0: q = 2;
        1: q = 65535;
        2: q = 13;
        default: q = longint'($urandom_range(2, 65535));
      endcase
      for (int c = 0; c < N; c++) op(1'b1, c, 1'b0, 1'b1, longint'($urandom_range(0, int'(q) - 1)), q);
      for (int k = 0; k < 200; k++) begin
        if (p == 3 && k == 100) do_reset();
        op(($urandom_range(0, 3) != 0), int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), longint'($urandom_range(0, int'(q) - 1)), q);
      end
    end
    drain(4);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
